jstk_spi_responder: RTL and testbench

SPI slave that emulates the PmodJSTK joystick on the far end of the same 4-wire link the joystick master drives. It serves a 5-byte position/button frame from parallel inputs and decodes the master's command byte into two LED bits. The team uses it as a loopback target for motor-control bring-up without the physical joystick, and as a board-to-board bridge.

---
 rtl/jstk_spi_responder.sv | 166 ++++++++++++++++
 tb/tb_jstk_spi_responder.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/jstk_spi_responder.sv
`default_nettype none
// ============================================================================
// Module  : jstk_spi_responder
// Brief   : SPI mode-0 slave emulating a PmodJSTK: serves a 40-bit position/
//           button frame and decodes the command byte into two LED bits.
//           Define JSTK_RESP_TRISTATE_EN to release MISO (high-Z) when idle.
// Revision: 1.0 - initial release
// ============================================================================
module jstk_spi_responder #(
  parameter int          SYNC_STAGES = 2,
  parameter logic [5:0]  CMD_PREFIX  = 6'b100000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       SS,
  input  logic       SCLK,
  input  logic       MOSI,
  output logic       MISO,
  input  logic [9:0] x_pos,
  input  logic [9:0] y_pos,
  input  logic [2:0] btn,
  output logic [1:0] led,
  output logic       frame_done,
  output logic       frame_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2
  } state_t;

  localparam logic [5:0] FRAME_BITS = 6'd40;

  logic [SYNC_STAGES-1:0] ss_sync_q;
  logic [SYNC_STAGES-1:0] sclk_sync_q;
  logic [SYNC_STAGES-1:0] mosi_sync_q;
  logic                   ss_prev_q;
  logic                   sclk_prev_q;

  state_t      state_q;
  logic [39:0] tx_sr_q;
  logic [7:0]  rx_sr_q;
  logic [5:0]  bit_cnt_q;
  logic        miso_q;
  logic [1:0]  led_q;
  logic        done_q;
  logic        err_q;

  logic        ss_s;
  logic        sclk_s;
  logic        mosi_s;
  logic        ss_fall;
  logic        ss_rise;
  logic        sclk_rise;
  logic        sclk_fall;
  logic [39:0] snapshot;

  // Synchronizers reset low so a reset released with SS already low never
  // fabricates an SS fall; a genuine frame needs a fresh falling edge.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      ss_sync_q   <= '0;
      sclk_sync_q <= '0;
      mosi_sync_q <= '0;
      ss_prev_q   <= 1'b0;
      sclk_prev_q <= 1'b0;
    end else begin
      ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0], SS};
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], SCLK};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], MOSI};
      ss_prev_q   <= ss_s;
      sclk_prev_q <= sclk_s;
    end
  end

  assign ss_s      = ss_sync_q[SYNC_STAGES-1];
  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign ss_fall   = ss_prev_q & ~ss_s;
  assign ss_rise   = ~ss_prev_q & ss_s;
  assign sclk_rise = ~sclk_prev_q & sclk_s;
  assign sclk_fall = sclk_prev_q & ~sclk_s;

  assign snapshot = {y_pos[7:0], 6'b0, y_pos[9:8],
                     x_pos[7:0], 6'b0, x_pos[9:8],
                     5'b0, btn};

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q   <= IDLE;
      tx_sr_q   <= '0;
      rx_sr_q   <= '0;
      bit_cnt_q <= '0;
      miso_q    <= 1'b0;
      led_q     <= 2'b00;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          miso_q    <= 1'b0;
          bit_cnt_q <= '0;
          if (ss_fall) begin
            state_q <= LOAD;
          end
        end
        LOAD: begin
          if (ss_rise) begin
            state_q <= IDLE;
          end else begin
            tx_sr_q <= snapshot;
            miso_q  <= snapshot[39];
            rx_sr_q <= '0;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          // SS rise takes priority over any coincident SCLK edge.
          if (ss_rise) begin
            state_q <= IDLE;
            miso_q  <= 1'b0;
            if (bit_cnt_q == FRAME_BITS) begin
              done_q <= 1'b1;
              if (rx_sr_q[7:2] == CMD_PREFIX) begin
                led_q <= rx_sr_q[1:0];
              end
            end else if (bit_cnt_q != 6'd0) begin
              err_q <= 1'b1;
            end
          end else begin
            if (sclk_rise) begin
              if (bit_cnt_q < 6'd8) begin
                rx_sr_q <= {rx_sr_q[6:0], mosi_s};
              end
              if (bit_cnt_q != FRAME_BITS) begin
                bit_cnt_q <= bit_cnt_q + 6'd1;
              end
            end
            if (sclk_fall) begin
              tx_sr_q <= {tx_sr_q[38:0], 1'b0};
              miso_q  <= tx_sr_q[38];
            end
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

`ifdef JSTK_RESP_TRISTATE_EN
  assign MISO = (state_q != IDLE) ? miso_q : 1'bz;
`else
  assign MISO = miso_q;
`endif

  assign led        = led_q;
  assign frame_done = done_q;
  assign frame_err  = err_q;

endmodule
`default_nettype wire

// File: tb/tb_jstk_spi_responder.sv
`default_nettype none
// ============================================================================
// Module  : tb_jstk_spi_responder
// Brief   : Directed self-checking bench for jstk_spi_responder.
// Revision: 1.0 - initial release
// ============================================================================
module tb_jstk_spi_responder;

  logic       CLK  = 1'b0;
  logic       RST  = 1'b0;
  logic       SS   = 1'b1;
  logic       SCLK = 1'b0;
  logic       MOSI = 1'b0;
  logic       MISO;
  logic [9:0] x_pos = 10'h2BC;
  logic [9:0] y_pos = 10'h12D;
  logic [2:0] btn   = 3'b101;
  logic [1:0] led;
  logic       frame_done;
  logic       frame_err;

  int checks   = 0;
  int errors   = 0;
  int done_cnt = 0;
  int err_cnt  = 0;

`ifdef JSTK_RESP_TRISTATE_EN
  localparam logic MISO_IDLE = 1'bz;
`else
  localparam logic MISO_IDLE = 1'b0;
`endif

  localparam logic [47:0] EXP_A = 48'h002D01BC0205;
  localparam logic [47:0] EXP_X0 = 48'h002D01000005;
  localparam logic [47:0] EXP_X1 = 48'h002D01FF0305;
  localparam logic [47:0] EXP_48 = 48'h2D01FF030500;

  jstk_spi_responder dut (
    .CLK        (CLK),
    .RST        (RST),
    .SS         (SS),
    .SCLK       (SCLK),
    .MOSI       (MOSI),
    .MISO       (MISO),
    .x_pos      (x_pos),
    .y_pos      (y_pos),
    .btn        (btn),
    .led        (led),
    .frame_done (frame_done),
    .frame_err  (frame_err)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK) begin
    if (frame_done) done_cnt++;
    if (frame_err)  err_cnt++;
  end

  task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge CLK);
  endtask

  // Mode-0 master: MOSI changes while SCLK low, MISO sampled at SCLK rise.
  task automatic spi_frame(input int nbits, input logic [47:0] mosi_v, input int half,
                           input int gap, input int chg_bit, input int rst_bit,
                           output logic [47:0] miso_v);
    miso_v = '0;
    @(negedge CLK);
    SS = 1'b0;
    wait_cyc(8);
    for (int i = 0; i < nbits; i++) begin
      if (i != 0 && (i % 8) == 0) wait_cyc(gap);
      if (i == chg_bit) x_pos = 10'h3FF;
      if (i == rst_bit) begin
        RST = 1'b0;
        wait_cyc(2);
        RST = 1'b1;
      end
      MOSI = mosi_v[nbits-1-i];
      wait_cyc(half);
      SCLK = 1'b1;
      miso_v = {miso_v[46:0], MISO};
      wait_cyc(half);
      SCLK = 1'b0;
    end
    wait_cyc(half);
    SS   = 1'b1;
    MOSI = 1'b0;
    wait_cyc(12);
  endtask

  initial begin
    logic [47:0] rx;
    int d0;
    int e0;

    wait_cyc(4);
    check("rst_miso", {47'b0, MISO}, {47'b0, MISO_IDLE});
    check("rst_led", {46'b0, led}, 48'd0);
    check("rst_done", {47'b0, frame_done}, 48'd0);
    check("rst_err", {47'b0, frame_err}, 48'd0);
    RST = 1'b1;
    wait_cyc(4);

    // Command 0x83 sets LED to 11
    d0 = done_cnt; e0 = err_cnt;
    spi_frame(40, {8'h00, 8'h83, 32'h0}, 8, 0, -1, -1, rx);
    check("f1_data", {8'h00, rx[39:0]}, EXP_A);
    check("f1_led", {46'b0, led}, 48'd3);
    check("f1_done", 48'(done_cnt - d0), 48'd1);
    check("f1_err", 48'(err_cnt - e0), 48'd0);

    // Command 0x40 has the wrong prefix: LED held
    d0 = done_cnt;
    spi_frame(40, {8'h00, 8'h40, 32'h0}, 8, 0, -1, -1, rx);
    check("f2_data", {8'h00, rx[39:0]}, EXP_A);
    check("f2_led", {46'b0, led}, 48'd3);
    check("f2_done", 48'(done_cnt - d0), 48'd1);

    // Truncated 17-bit frame
    d0 = done_cnt; e0 = err_cnt;
    spi_frame(17, 48'h81 << 9, 8, 0, -1, -1, rx);
    check("trunc_err", 48'(err_cnt - e0), 48'd1);
    check("trunc_done", 48'(done_cnt - d0), 48'd0);
    check("trunc_led", {46'b0, led}, 48'd3);

    // Recovery frame, command 0x81
    d0 = done_cnt;
    spi_frame(40, {8'h00, 8'h81, 32'h0}, 8, 0, -1, -1, rx);
    check("rec_data", {8'h00, rx[39:0]}, EXP_A);
    check("rec_led", {46'b0, led}, 48'd1);
    check("rec_done", 48'(done_cnt - d0), 48'd1);

    // X changes mid-frame: frame keeps the LOAD snapshot
    x_pos = 10'h000;
    spi_frame(40, {8'h00, 8'h00, 32'h0}, 8, 0, 10, -1, rx);
    check("xchg_data", {8'h00, rx[39:0]}, EXP_X0);
    check("xchg_led", {46'b0, led}, 48'd1);
    spi_frame(40, {8'h00, 8'h82, 32'h0}, 8, 0, -1, -1, rx);
    check("xnext_data", {8'h00, rx[39:0]}, EXP_X1);
    check("xnext_led", {46'b0, led}, 48'd2);

    // Slow SCLK with long inter-byte gaps
    d0 = done_cnt;
    spi_frame(40, {8'h00, 8'h83, 32'h0}, 25, 2000, -1, -1, rx);
    check("gap_data", {8'h00, rx[39:0]}, EXP_X1);
    check("gap_led", {46'b0, led}, 48'd3);
    check("gap_done", 48'(done_cnt - d0), 48'd1);

    // 48-bit frame: trailing MISO bits are zero, counter saturates
    d0 = done_cnt;
    spi_frame(48, {8'h81, 40'h0}, 8, 0, -1, -1, rx);
    check("f48_data", rx, EXP_48);
    check("f48_led", {46'b0, led}, 48'd1);
    check("f48_done", 48'(done_cnt - d0), 48'd1);

    // Reset during byte 2 aborts the frame silently
    d0 = done_cnt; e0 = err_cnt;
    spi_frame(40, {8'h00, 8'h83, 32'h0}, 8, 0, -1, 12, rx);
    check("rstmid_done", 48'(done_cnt - d0), 48'd0);
    check("rstmid_err", 48'(err_cnt - e0), 48'd0);
    check("rstmid_led", {46'b0, led}, 48'd0);
    check("rstmid_miso", {47'b0, MISO}, {47'b0, MISO_IDLE});

    // Fresh frame after the aborted one
    d0 = done_cnt;
    spi_frame(40, {8'h00, 8'h00, 32'h0}, 8, 0, -1, -1, rx);
    check("post_data", {8'h00, rx[39:0]}, EXP_X1);
    check("post_done", 48'(done_cnt - d0), 48'd1);
    check("post_led", {46'b0, led}, 48'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
